store_unit: RTL
===============

# store_unit

Parametrised MEM-stage store unit that handles SB/SH/SW. It computes the effective address and byte enables, replicates data onto byte lanes, and buffers accepted stores in an in-order FIFO. The FIFO drains to the data memory over a valid/ready handshake. It sits between the register-read/execute path and data memory.

## Interface
Parameters:
- DATA_W, 32, memory data width; 32 or 64.
- ADDR_W, 32, effective-address width.
- DEPTH, 4, store buffer entries; power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- instruction  in  32  I-format: opcode[31:26], rs[25:21], rt[20:16], imm[15:0].
- Read_data1  in  DATA_W  base register (rs).
- Read_data2  in  DATA_W  store data (rt).
- issue_valid  in  1  instruction/operands valid this cycle.
- issue_ready  out  1  buffer can accept (count < DEPTH).
- ALU_result  out  ADDR_W  combinational effective address, Read_data1[ADDR_W-1:0] + sign-extended imm.
- MemWrite  out  1  memory write request valid; head entry present.
- mem_addr  out  ADDR_W  head address, lane-offset bits forced to 0.
- Write_data  out  DATA_W  head data, lane-replicated.
- byte_en  out  DATA_W/8  head byte enables.
- mem_ready  in  1  memory accepts the write this cycle.
- misalign  out  1  one-cycle pulse: store was dropped for misalignment.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Opcodes: SB=6'b101000, SH=6'b101001, SW=6'b101011; SD=6'b111111 only when DATA_W=64. Any other opcode is ignored: no enqueue, no misalign.
- Lane offset: off = ALU_result[L-1:0], where L = log2(DATA_W/8).
- SB: byte_en = 1<<off. Write_data = Read_data2[7:0] replicated on every lane.
- SH: off[0] must be 0. byte_en = 2'b11<<off. Write_data = halfword replicated.
- SW: off[1:0] must be 0. byte_en = 4'hF<<off. Write_data = word replicated.
- SD: off must be 0. All byte enables set.
- A store is accepted when issue_valid && issue_ready && (store opcode) && aligned. It is written at the FIFO tail.
- A misaligned store is never enqueued. misalign=1 in the following cycle for exactly one cycle.
- A misaligned store presented while full still raises misalign.
- Head dequeues when MemWrite && mem_ready. Order is strictly in-order.
- MemWrite is high whenever count>0, and holds until accepted. mem_addr, Write_data and byte_en are stable while MemWrite && !mem_ready.
- issue_ready = (count != DEPTH). There is no same-cycle pass-through when full, even if the head dequeues.
- Enqueue and dequeue in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH.
- Address arithmetic is modulo 2^ADDR_W; carry is discarded and negative offsets wrap.

## Timing
- Reset (async, immediate): count=0, pointers=0, MemWrite=0, misalign=0, mem_addr=0, Write_data=0, byte_en=0, issue_ready=1. Reset mid-drain discards all entries.
- ALU_result: zero latency, combinational.
- Accept-to-MemWrite latency: 1 cycle when the buffer is empty.
- Throughput: 1 store/cycle in and 1 store/cycle out.
- Head outputs are registered (driven from FIFO storage) and are 0 when empty.

## Structure
- Package store_pkg holds:
  - opcode localparams SB/SH/SW/SD;
  - store_entry_t {addr, data, be};
  - functions lane_replicate() and make_byte_en().
- Sub-module store_fifo (DEPTH × store_entry_t): push/pop, full/empty, count, async reset.
- Top level: decode, address adder, alignment check, misalign register.

## Test plan
- SW: instruction=32'b101011_00100_01001_0000000000000100, Read_data1=0, Read_data2=0x12345678, mem_ready=1 → ALU_result=0x4 same cycle. Next cycle: MemWrite=1, mem_addr=0x4, Write_data=0x12345678, byte_en=4'b1111. Then count=0.
- SB: imm=0x0021, Read_data1=0x1C, Read_data2=0xABCDEF01 → addr 0x3D, mem_addr=0x3C, byte_en=4'b0010, Write_data=0x01010101.
- Negative offset and misalignment:
  - SW with imm=0xFFFC, Read_data1=0x20 → mem_addr=0x1C.
  - SH with Read_data1=0x3, imm=0 → misalign pulses for 1 cycle; count stays 0; MemWrite stays 0.
- Full/backpressure: mem_ready=0, issue 4 SWs (data 1..4) → count=4, issue_ready=0, 5th store not accepted. Then mem_ready=1 → data 1,2,3,4 drained on 4 consecutive cycles, issue_ready=1 after the first drain.
- Simultaneous push/pop: count=2, accept one store while the head drains → count stays 2, and FIFO order is preserved.
- Reset mid-operation: count=3, mem_ready=0; assert reset between edges → MemWrite=0 and count=0 immediately. After deassert, the first new store appears with the correct data.

Source files
------------

// File: rtl/store_unit_pkg.sv
// Shared opcodes, entry layout and lane helpers for the MEM-stage store unit.
// Entries are sized for the widest configuration; narrower instances truncate on readout.
package store_pkg;

  localparam logic [5:0] SB = 6'b101000;
  localparam logic [5:0] SH = 6'b101001;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] SD = 6'b111111;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_ADDR_W = 64;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD,
    SZ_DWORD
  } store_size_t;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] data;
    logic [MAX_BE_W-1:0]   be;
  } store_entry_t;

  // The replicated pattern is periodic, so the low DATA_W bits are correct for any width.
  function automatic logic [MAX_DATA_W-1:0] lane_replicate(input logic [MAX_DATA_W-1:0] d,
                                                           input store_size_t sz);
    case (sz)
      SZ_BYTE: lane_replicate = {8{d[7:0]}};
      SZ_HALF: lane_replicate = {4{d[15:0]}};
      SZ_WORD: lane_replicate = {2{d[31:0]}};
      default: lane_replicate = d;
    endcase
  endfunction

  function automatic logic [MAX_BE_W-1:0] make_byte_en(input store_size_t sz,
                                                       input logic [2:0] off);
    case (sz)
      SZ_BYTE: make_byte_en = 8'h01 << off;
      SZ_HALF: make_byte_en = 8'h03 << off;
      SZ_WORD: make_byte_en = 8'h0F << off;
      default: make_byte_en = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/store_unit_if.sv
// Issue-side and memory-side signals of the store unit; master drives issue, slave is the unit.
interface store_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
);

  logic [31:0]              instruction;
  logic [DATA_W-1:0]        Read_data1;
  logic [DATA_W-1:0]        Read_data2;
  logic                     issue_valid;
  logic                     issue_ready;
  logic [ADDR_W-1:0]        ALU_result;
  logic                     MemWrite;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        Write_data;
  logic [DATA_W/8-1:0]      byte_en;
  logic                     mem_ready;
  logic                     misalign;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output instruction, Read_data1, Read_data2, issue_valid, mem_ready,
    input  issue_ready, ALU_result, MemWrite, mem_addr, Write_data, byte_en, misalign, count
  );

  modport slave (
    input  instruction, Read_data1, Read_data2, issue_valid, mem_ready,
    output issue_ready, ALU_result, MemWrite, mem_addr, Write_data, byte_en, misalign, count
  );

endinterface

// File: rtl/store_unit_fifo.sv
// In-order store buffer; head is read straight from storage and reads as zero when empty.
module store_fifo
  import store_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  store_entry_t           push_entry,
  input  logic                   pop,
  output store_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  store_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/store_unit.sv
// MEM-stage store unit: decodes SB/SH/SW(/SD), forms the effective address and lane data,
// drops misaligned stores with a one-cycle flag, and queues the rest for data memory.
module store_unit
  import store_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input logic         clk,
  input logic         reset,
  store_unit_if.slave bus
);

  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);

  logic [5:0]              opcode;
  logic [15:0]             imm;
  logic                    is_store;
  store_size_t             size;
  logic [LANE_W-1:0]       off;
  logic [LANE_W-1:0]       align_mask;
  logic                    aligned;
  logic                    accept;
  logic                    bad_align;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  store_entry_t            push_entry;
  store_entry_t            head;
  logic                    unused_bits;

  assign opcode = bus.instruction[31:26];
  assign imm    = bus.instruction[15:0];
  assign unused_bits = ^{bus.instruction[25:16], head};

  assign bus.ALU_result = ADDR_W'(bus.Read_data1) + {{(ADDR_W-16){imm[15]}}, imm};
  assign off = bus.ALU_result[LANE_W-1:0];

  // SD is only a store on 64-bit datapaths; everything else is silently ignored.
  always_comb begin
    is_store   = 1'b1;
    size       = SZ_WORD;
    align_mask = '1;
    case (opcode)
      SB: begin size = SZ_BYTE; align_mask = '0;          end
      SH: begin size = SZ_HALF; align_mask = LANE_W'(1);  end
      SW: begin size = SZ_WORD; align_mask = LANE_W'(3);  end
      SD: begin size = SZ_DWORD; is_store = (DATA_W == 64); end
      default: is_store = 1'b0;
    endcase
  end

  assign aligned   = ((off & align_mask) == '0);
  assign accept    = bus.issue_valid && !fifo_full && is_store && aligned;
  assign bad_align = bus.issue_valid && is_store && !aligned;

  always_comb begin
    push_entry      = '0;
    push_entry.addr = MAX_ADDR_W'({bus.ALU_result[ADDR_W-1:LANE_W], {LANE_W{1'b0}}});
    push_entry.data = lane_replicate(MAX_DATA_W'(bus.Read_data2), size);
    push_entry.be   = make_byte_en(size, 3'(off));
  end

  // Misalignment is flagged even when the buffer is full, since the store is dropped either way.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.misalign <= 1'b0;
    else       bus.misalign <= bad_align;
  end

  store_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (bus.mem_ready),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign bus.issue_ready = !fifo_full;
  assign bus.MemWrite    = !fifo_empty;
  assign bus.mem_addr    = ADDR_W'(head.addr);
  assign bus.Write_data  = DATA_W'(head.data);
  assign bus.byte_en     = BE_W'(head.be);
  assign bus.count       = fifo_count;

endmodule
